// File: rtl/c432_key_loader_if.sv
// Key-provisioning bus between the provisioning port (master) and c432_key_loader (slave).
interface c432_key_loader_if #(parameter int KEY_W = 16);
    logic             load_start;
    logic             key_bit;
    logic             key_bit_vld;
    logic [KEY_W-1:0] key_o;
    logic             key_loaded;
    logic             busy;
    logic             key_err;

    modport master (
        output load_start, key_bit, key_bit_vld,
        input  key_o, key_loaded, busy, key_err
    );

    modport slave (
        input  load_start, key_bit, key_bit_vld,
        output key_o, key_loaded, busy, key_err
    );
endinterface

// File: rtl/c432_key_loader.sv
// Serial key loader for the mux4-locked c432: shifts a key into a shadow register and applies it atomically.
// Optional odd-parity check on a trailing bit is compiled in with `define C432_KEY_PARITY_EN.
module c432_key_loader #(
    parameter int KEY_W     = 16,
    parameter int MSB_FIRST = 0
) (
    input logic          clk,
    input logic          rst,
    c432_key_loader_if.slave bus
);
    localparam int CW = $clog2(KEY_W + 1);
    localparam int IW = (KEY_W > 1) ? $clog2(KEY_W) : 1;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SHIFT  = 3'd1;
    localparam logic [2:0] LOADED = 3'd3;
`ifdef C432_KEY_PARITY_EN
    localparam logic [2:0] PAR    = 3'd2;
    localparam logic [2:0] ERROR  = 3'd4;
`endif

    logic [2:0]       state;
    logic [CW-1:0]    cnt;
    logic [KEY_W-1:0] shadow;
    logic [KEY_W-1:0] shadow_nxt;
    logic [KEY_W-1:0] key_q;
    logic             loaded_q;
    logic [IW-1:0]    pos;
    logic             last_bit;

    always_comb begin
        pos        = (MSB_FIRST != 0) ? IW'(KEY_W - 1) - cnt[IW-1:0] : cnt[IW-1:0];
        shadow_nxt = shadow;
        shadow_nxt[pos] = bus.key_bit;
        last_bit   = (cnt == CW'(KEY_W - 1));
    end

`ifdef C432_KEY_PARITY_EN
    logic err_q;
    assign bus.key_err = err_q;
    assign bus.busy    = (state == SHIFT) || (state == PAR);
`else
    assign bus.key_err = 1'b0;
    assign bus.busy    = (state == SHIFT);
`endif
    assign bus.key_o      = key_q;
    assign bus.key_loaded = loaded_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            shadow   <= '0;
            key_q    <= '0;
            loaded_q <= 1'b0;
`ifdef C432_KEY_PARITY_EN
            err_q    <= 1'b0;
`endif
        end else begin
            case (state)
                SHIFT: begin
                    // load_start outranks a coincident bit: the partial key is dropped
                    if (bus.load_start) begin
                        cnt    <= '0;
                        shadow <= '0;
                    end else if (bus.key_bit_vld) begin
                        shadow <= shadow_nxt;
                        cnt    <= cnt + 1'b1;
                        if (last_bit) begin
`ifdef C432_KEY_PARITY_EN
                            state    <= PAR;
`else
                            state    <= LOADED;
                            key_q    <= shadow_nxt;
                            loaded_q <= 1'b1;
`endif
                        end
                    end
                end
`ifdef C432_KEY_PARITY_EN
                PAR: begin
                    if (bus.load_start) begin
                        state  <= SHIFT;
                        cnt    <= '0;
                        shadow <= '0;
                    end else if (bus.key_bit_vld) begin
                        if ((^shadow ^ bus.key_bit) == 1'b1) begin
                            state    <= LOADED;
                            key_q    <= shadow;
                            loaded_q <= 1'b1;
                        end else begin
                            state    <= ERROR;
                            key_q    <= '0;
                            loaded_q <= 1'b0;
                            err_q    <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    // IDLE, LOADED, ERROR: only load_start matters; the applied key is kept
                    if (bus.load_start) begin
                        state  <= SHIFT;
                        cnt    <= '0;
                        shadow <= '0;
`ifdef C432_KEY_PARITY_EN
                        err_q  <= 1'b0;
`endif
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_c432_key_loader.sv
// Randomized + directed bench for c432_key_loader; an LSB-first and an MSB-first instance share one stimulus.
module tb_c432_key_loader;
    localparam int KEY_W = 16;
`ifdef C432_KEY_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic load_start = 1'b0;
    logic key_bit = 1'b0;
    logic key_bit_vld = 1'b0;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    c432_key_loader_if #(.KEY_W(KEY_W)) bus0 ();
    c432_key_loader_if #(.KEY_W(KEY_W)) bus1 ();

    assign bus0.load_start  = load_start;
    assign bus0.key_bit     = key_bit;
    assign bus0.key_bit_vld = key_bit_vld;
    assign bus1.load_start  = load_start;
    assign bus1.key_bit     = key_bit;
    assign bus1.key_bit_vld = key_bit_vld;

    c432_key_loader #(.KEY_W(KEY_W), .MSB_FIRST(0)) dut_lsb (.clk(clk), .rst(rst), .bus(bus0.slave));
    c432_key_loader #(.KEY_W(KEY_W), .MSB_FIRST(1)) dut_msb (.clk(clk), .rst(rst), .bus(bus1.slave));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a list of received bits, packed into a key only on completion.
    bit        m_busy, m_loaded, m_err;
    int        m_n;
    bit        m_bits[KEY_W];
    bit [15:0] m_key_lsb, m_key_msb;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 0; m_loaded = 0; m_err = 0; m_n = 0;
            m_key_lsb = '0; m_key_msb = '0;
        end else if (load_start) begin
            m_busy = 1; m_n = 0;
            if (m_n == 0) m_err = 0;
        end else if (m_busy && key_bit_vld) begin
            if (m_n < KEY_W) begin
                m_bits[m_n] = key_bit;
                m_n++;
            end else begin
                m_n++;
            end
            if (m_n == KEY_W + PAR) begin
                int ones;
                ones = key_bit;
                for (int i = 0; i < KEY_W; i++) ones += m_bits[i];
                m_busy = 0;
                if (PAR == 0 || (ones % 2) == 1) begin
                    m_key_lsb = '0; m_key_msb = '0;
                    for (int i = 0; i < KEY_W; i++) begin
                        m_key_lsb[i]           = m_bits[i];
                        m_key_msb[KEY_W-1-i]   = m_bits[i];
                    end
                    m_loaded = 1;
                end else begin
                    m_key_lsb = '0; m_key_msb = '0;
                    m_loaded = 0; m_err = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("key_o_lsb",  32'(bus0.key_o),      32'(m_key_lsb));
            chk("key_o_msb",  32'(bus1.key_o),      32'(m_key_msb));
            chk("key_loaded", 32'(bus0.key_loaded), 32'(m_loaded));
            chk("busy",       32'(bus0.busy),       32'(m_busy));
            chk("key_err",    32'(bus0.key_err),    32'(m_err));
        end
    end

    task automatic cyc(input bit ls, input bit vld, input bit b);
        load_start = ls; key_bit_vld = vld; key_bit = b;
        @(posedge clk); #1;
        load_start = 0; key_bit_vld = 0;
    endtask

    function automatic bit pbit(input logic [15:0] k);
        return ~(^k);
    endfunction

    int busy_cnt;

    // Streams k LSB-first; optional idle gap between bits; optional literal hold check on key_o.
    task automatic send_key(input logic [15:0] k, input bit gap, input bit good_par,
                            input bit hold_en, input logic [15:0] hold);
        for (int i = 0; i < KEY_W; i++) begin
            if (gap && i > 0) cyc(0, 0, 0);
            if (hold_en) chk("key_hold", 32'(bus0.key_o), 32'(hold));
            if (bus0.busy) busy_cnt++;
            cyc(0, 1, k[i]);
        end
        if (PAR != 0) begin
            if (hold_en) chk("key_hold_par", 32'(bus0.key_o), 32'(hold));
            if (bus0.busy) busy_cnt++;
            cyc(0, 1, good_par ? pbit(k) : ~pbit(k));
        end
    endtask

    task automatic do_reset();
        rst = 1; cyc(0, 0, 0); cyc(0, 0, 0); rst = 0;
    endtask

    initial begin
        do_reset();
        chk_en = 1;
        chk("rst_key", 32'(bus0.key_o), 32'h0);
        chk("rst_loaded", 32'(bus0.key_loaded), 32'h0);
        chk("rst_busy", 32'(bus0.busy), 32'h0);
        chk("rst_err", 32'(bus0.key_err), 32'h0);

        // back-to-back 0xA5C3
        cyc(1, 0, 0);
        busy_cnt = 0;
        send_key(16'hA5C3, 0, 1, 1, 16'h0000);
        chk("a5c3_key", 32'(bus0.key_o), 32'h0000A5C3);
        chk("a5c3_loaded", 32'(bus0.key_loaded), 32'h1);
        chk("a5c3_busy_after", 32'(bus0.busy), 32'h0);
        chk("a5c3_busy_cycles", 32'(busy_cnt), 32'(KEY_W + PAR));

        // toggling valid, from a fresh reset so the held key is 0
        do_reset();
        cyc(1, 0, 0);
        send_key(16'hA5C3, 1, 1, 1, 16'h0000);
        chk("a5c3_gap_key", 32'(bus0.key_o), 32'h0000A5C3);
        chk("a5c3_gap_loaded", 32'(bus0.key_loaded), 32'h1);

`ifdef C432_KEY_PARITY_EN
        cyc(1, 0, 0);
        send_key(16'h0001, 0, 1, 0, 16'h0);
        chk("par_ok_key", 32'(bus0.key_o), 32'h1);
        chk("par_ok_err", 32'(bus0.key_err), 32'h0);
        cyc(1, 0, 0);
        send_key(16'h0001, 0, 0, 0, 16'h0);
        chk("par_bad_key", 32'(bus0.key_o), 32'h0);
        chk("par_bad_loaded", 32'(bus0.key_loaded), 32'h0);
        chk("par_bad_err", 32'(bus0.key_err), 32'h1);
        cyc(1, 0, 0);
        chk("err_clear", 32'(bus0.key_err), 32'h0);
`endif

        // restart mid-load keeps the old key until the new one completes
        cyc(1, 0, 0);
        send_key(16'hFFFF, 0, 1, 0, 16'h0);
        chk("ffff_key", 32'(bus0.key_o), 32'h0000FFFF);
        cyc(1, 0, 0);
        for (int i = 0; i < 7; i++) cyc(0, 1, 1'b0);
        cyc(1, 1, 1'b1);
        send_key(16'h1234, 0, 1, 1, 16'hFFFF);
        chk("restart_key", 32'(bus0.key_o), 32'h00001234);

        // reset mid-load clears a previously applied key
        cyc(1, 0, 0);
        send_key(16'hBEEF, 0, 1, 0, 16'h0);
        chk("beef_key", 32'(bus0.key_o), 32'h0000BEEF);
        cyc(1, 0, 0);
        for (int i = 0; i < 9; i++) cyc(0, 1, 1'b1);
        rst = 1; cyc(0, 0, 0); rst = 0;
        chk("rst_mid_key", 32'(bus0.key_o), 32'h0);
        chk("rst_mid_loaded", 32'(bus0.key_loaded), 32'h0);
        chk("rst_mid_busy", 32'(bus0.busy), 32'h0);
        for (int i = 0; i < 20; i++) cyc(0, 1, 1'b1);
        chk("ignored_busy", 32'(bus0.busy), 32'h0);
        chk("ignored_key", 32'(bus0.key_o), 32'h0);

        // single leading one: p1 for LSB-first, p16 for MSB-first
        cyc(1, 0, 0);
        send_key(16'h0001, 0, 1, 0, 16'h0);
        chk("msb_first_key", 32'(bus1.key_o), 32'h00008000);
        chk("lsb_first_key", 32'(bus0.key_o), 32'h00000001);

        // random loads with gaps, restarts, coincident start+bit, bad parity and resets
        for (int r = 0; r < 60; r++) begin
            logic [15:0] k;
            int i;
            int n;
            k = 16'($urandom);
            n = KEY_W + PAR;
            cyc(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            i = 0;
            while (i < n) begin
                int a;
                a = $urandom_range(0, 99);
                if (a < 3) begin
                    cyc(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                    i = 0;
                end else if (a < 4) begin
                    rst = 1; cyc(0, 0, 0); rst = 0;
                    i = n;
                end else if (a < 25) begin
                    cyc(0, 0, 1'($urandom_range(0, 1)));
                end else begin
                    bit b;
                    if (i < KEY_W) b = k[i];
                    else b = ($urandom_range(0, 9) < 7) ? pbit(k) : ~pbit(k);
                    cyc(0, 1, b);
                    i++;
                end
            end
            for (int g = $urandom_range(0, 3); g > 0; g--) cyc(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        cyc(0, 0, 0);
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
